// File: rtl/xadc_drp_sequencer.sv
// XADC DRP read sequencer: one DRP read per end-of-conversion on a mapped channel,
// with drdy timeout, a single-entry pending slot and a per-slot 12-bit sample bank.
module xadc_drp_sequencer #(
  parameter int unsigned        NCH     = 4,
  parameter logic [5*NCH-1:0]   CH_MAP  = {5'd15, 5'd14, 5'd7, 5'd6},
  parameter int unsigned        TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  output logic        drp_den,
  output logic [6:0]  drp_daddr,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        sample_valid,
  output logic [2:0]  sample_slot,
  output logic [11:0] sample_data,
  input  logic [2:0]  rd_slot,
  output logic [11:0] rd_data,
  output logic        overrun,
  output logic        timeout_err,
  input  logic        clr_err
);

  localparam int unsigned BANK_N  = 8;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
  localparam logic [3:0]  NCH_C   = 4'(NCH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_eoc_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_slot;
  logic               r_pend_v;
  logic [2:0]         r_pend_slot;
  logic [4:0]         r_pend_ch;
  logic               r_den;
  logic [6:0]         r_daddr;
  logic               r_sample_valid;
  logic [2:0]         r_sample_slot;
  logic [11:0]        r_sample_data;
  logic [11:0]        r_rd_data;
  logic               r_overrun;
  logic               r_timeout_err;
  logic [11:0]        r_bank [BANK_N];

  logic               w_evt;
  logic               w_hit;
  logic [2:0]         w_slot;
  logic               w_take;
  logic               w_unused;

  assign w_evt    = eoc_in & ~r_eoc_d;
  assign w_take   = w_evt & w_hit;
  assign w_unused = ^drp_do[3:0];

  // Channel-to-slot lookup; scanning downward lets the lowest matching slot win.
  always_comb begin
    w_hit  = 1'b0;
    w_slot = 3'd0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (channel_in == CH_MAP[5*i +: 5]) begin
        w_hit  = 1'b1;
        w_slot = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state        <= S_IDLE;
      r_eoc_d        <= 1'b0;
      r_cnt          <= '0;
      r_slot         <= '0;
      r_pend_v       <= 1'b0;
      r_pend_slot    <= '0;
      r_pend_ch      <= '0;
      r_den          <= 1'b0;
      r_daddr        <= '0;
      r_sample_valid <= 1'b0;
      r_sample_slot  <= '0;
      r_sample_data  <= '0;
      r_rd_data      <= '0;
      r_overrun      <= 1'b0;
      r_timeout_err  <= 1'b0;
      for (int i = 0; i < int'(BANK_N); i++) r_bank[i] <= '0;
    end else begin
      r_eoc_d        <= eoc_in;
      r_den          <= 1'b0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      // Read port samples the bank before any write made on this edge.
      r_rd_data      <= ({1'b0, rd_slot} < NCH_C) ? r_bank[rd_slot] : 12'd0;
      if (clr_err) r_timeout_err <= 1'b0;

      if (w_take && (r_state != S_IDLE)) begin
        r_overrun   <= r_pend_v;
        r_pend_v    <= 1'b1;
        r_pend_slot <= w_slot;
        r_pend_ch   <= channel_in;
      end

      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_slot  <= w_slot;
            r_daddr <= {2'b00, channel_in};
            r_den   <= 1'b1;
            r_state <= S_ISSUE;
          end else if (r_pend_v) begin
            r_slot   <= r_pend_slot;
            r_daddr  <= {2'b00, r_pend_ch};
            r_den    <= 1'b1;
            r_pend_v <= 1'b0;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (drp_drdy) begin
            // Accepted data lands in the bank as the STORE cycle begins.
            r_bank[r_slot] <= drp_do[15:4];
            r_sample_slot  <= r_slot;
            r_sample_data  <= drp_do[15:4];
            r_sample_valid <= 1'b1;
            r_state        <= S_STORE;
          end else if (r_cnt == TO_CNT) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_STORE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drp_den      = r_den;
  assign drp_daddr    = r_daddr;
  assign sample_valid = r_sample_valid;
  assign sample_slot  = r_sample_slot;
  assign sample_data  = r_sample_data;
  assign rd_data      = r_rd_data;
  assign overrun      = r_overrun;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed bench for xadc_drp_sequencer with hand-computed expectations.
module tb_xadc_drp_sequencer;

  logic        clk;
  logic        reset_p;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        drp_den;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        sample_valid;
  logic [2:0]  sample_slot;
  logic [11:0] sample_data;
  logic [2:0]  rd_slot;
  logic [11:0] rd_data;
  logic        overrun;
  logic        timeout_err;
  logic        clr_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_den = 0;
  int n_sv  = 0;
  int n_ovr = 0;
  int n_sv_slot [8] = '{default: 0};
  int s_den, s_sv, s_ovr, s_slot2;

  xadc_drp_sequencer dut (
    .clk          (clk),
    .reset_p      (reset_p),
    .eoc_in       (eoc_in),
    .channel_in   (channel_in),
    .drp_den      (drp_den),
    .drp_daddr    (drp_daddr),
    .drp_do       (drp_do),
    .drp_drdy     (drp_drdy),
    .sample_valid (sample_valid),
    .sample_slot  (sample_slot),
    .sample_data  (sample_data),
    .rd_slot      (rd_slot),
    .rd_data      (rd_data),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled at the edge (values of the cycle just ending).
  always @(posedge clk) begin
    if (drp_den) n_den = n_den + 1;
    if (overrun) n_ovr = n_ovr + 1;
    if (sample_valid) begin
      n_sv = n_sv + 1;
      n_sv_slot[sample_slot] = n_sv_slot[sample_slot] + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Event at c0, drdy presented in c2 (k=0), checks STORE outputs in c3; returns in c4 (IDLE).
  task automatic xact(input logic [4:0] ch, input logic [15:0] d, input logic [2:0] slot);
    eoc_in = 1'b1; channel_in = ch;
    tick();
    eoc_in = 1'b0;
    chk("scan_den", 32'(drp_den), 32'd1);
    tick();
    drp_drdy = 1'b1; drp_do = d;
    tick();
    drp_drdy = 1'b0;
    chk("scan_sv", 32'(sample_valid), 32'd1);
    chk("scan_slot", 32'(sample_slot), 32'(slot));
    chk("scan_data", 32'(sample_data), 32'(d[15:4]));
    tick();
  endtask

  logic [11:0] exp_bank [4];
  logic [4:0]  scan_ch  [4];

  initial begin
    reset_p = 1'b1; eoc_in = 1'b0; channel_in = 5'd0; drp_do = 16'd0;
    drp_drdy = 1'b0; rd_slot = 3'd0; clr_err = 1'b0;
    ticks(3);
    reset_p = 1'b0;
    tick();

    // Reset state
    chk("rst_den",   32'(drp_den), 32'd0);
    chk("rst_daddr", 32'(drp_daddr), 32'd0);
    chk("rst_sv",    32'(sample_valid), 32'd0);
    chk("rst_sslot", 32'(sample_slot), 32'd0);
    chk("rst_sdata", 32'(sample_data), 32'd0);
    chk("rst_rd",    32'(rd_data), 32'd0);
    chk("rst_ovr",   32'(overrun), 32'd0);
    chk("rst_terr",  32'(timeout_err), 32'd0);

    // 1: channel 6, drdy two cycles after den, data 16'hABC0
    s_den = n_den;
    eoc_in = 1'b1; channel_in = 5'd6;
    tick();
    eoc_in = 1'b0;
    chk("t1_den", 32'(drp_den), 32'd1);
    chk("t1_daddr", 32'(drp_daddr), 32'h06);
    tick();
    chk("t1_den_low", 32'(drp_den), 32'd0);
    tick();
    drp_drdy = 1'b1; drp_do = 16'hABC0;
    tick();
    drp_drdy = 1'b0;
    chk("t1_sv", 32'(sample_valid), 32'd1);
    chk("t1_slot", 32'(sample_slot), 32'd0);
    chk("t1_data", 32'(sample_data), 32'hABC);
    chk("t1_rd_old", 32'(rd_data), 32'd0);
    tick();
    chk("t1_rd_new", 32'(rd_data), 32'hABC);
    chk("t1_sv_low", 32'(sample_valid), 32'd0);
    chk("t1_den_cnt", 32'(n_den - s_den), 32'd1);

    // 2: unmapped channel 3 is dropped
    s_den = n_den; s_sv = n_sv;
    eoc_in = 1'b1; channel_in = 5'd3;
    tick();
    eoc_in = 1'b0;
    ticks(50);
    chk("t2_den_cnt", 32'(n_den - s_den), 32'd0);
    chk("t2_sv_cnt", 32'(n_sv - s_sv), 32'd0);
    chk("t2_rd", 32'(rd_data), 32'hABC);

    // 3: ch7 starts, ch14 pends during WAIT, ch15 overwrites it
    s_den = n_den; s_ovr = n_ovr; s_slot2 = n_sv_slot[2];
    eoc_in = 1'b1; channel_in = 5'd7;
    tick();
    eoc_in = 1'b0;
    tick();
    eoc_in = 1'b1; channel_in = 5'd14;
    tick();
    eoc_in = 1'b0;
    tick();
    eoc_in = 1'b1; channel_in = 5'd15;
    tick();
    eoc_in = 1'b0;
    chk("t3_ovr", 32'(overrun), 32'd1);
    drp_drdy = 1'b1; drp_do = 16'h1110;
    tick();
    drp_drdy = 1'b0;
    chk("t3_ovr_low", 32'(overrun), 32'd0);
    chk("t3_sv1", 32'(sample_valid), 32'd1);
    chk("t3_slot1", 32'(sample_slot), 32'd1);
    chk("t3_data1", 32'(sample_data), 32'h111);
    tick();
    chk("t3_idle_den", 32'(drp_den), 32'd0);
    tick();
    chk("t3_den2", 32'(drp_den), 32'd1);
    chk("t3_daddr2", 32'(drp_daddr), 32'h0F);
    tick();
    drp_drdy = 1'b1; drp_do = 16'h3330;
    tick();
    drp_drdy = 1'b0;
    chk("t3_sv3", 32'(sample_valid), 32'd1);
    chk("t3_slot3", 32'(sample_slot), 32'd3);
    chk("t3_data3", 32'(sample_data), 32'h333);
    ticks(10);
    chk("t3_den_cnt", 32'(n_den - s_den), 32'd2);
    chk("t3_ovr_cnt", 32'(n_ovr - s_ovr), 32'd1);
    chk("t3_slot2_cnt", 32'(n_sv_slot[2] - s_slot2), 32'd0);
    rd_slot = 3'd2;
    tick(); tick();
    chk("t3_rd2", 32'(rd_data), 32'd0);
    rd_slot = 3'd1;
    tick(); tick();
    chk("t3_rd1", 32'(rd_data), 32'h111);

    // 4a: timeout on ch6, then stray drdy ignored, then clr_err
    s_den = n_den; s_sv = n_sv;
    eoc_in = 1'b1; channel_in = 5'd6;
    tick();
    eoc_in = 1'b0;
    ticks(32);
    chk("t4_terr_c33", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_terr_c34", 32'(timeout_err), 32'd1);
    drp_drdy = 1'b1; drp_do = 16'hFFF0;
    ticks(3);
    drp_drdy = 1'b0;
    ticks(2);
    chk("t4_sv_cnt", 32'(n_sv - s_sv), 32'd0);
    chk("t4_den_cnt", 32'(n_den - s_den), 32'd1);
    rd_slot = 3'd0;
    tick(); tick();
    chk("t4_rd0", 32'(rd_data), 32'hABC);
    chk("t4_terr_sticky", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("t4_terr_clr", 32'(timeout_err), 32'd0);

    // 4b: drdy in the last allowed WAIT cycle is accepted
    eoc_in = 1'b1; channel_in = 5'd7;
    tick();
    eoc_in = 1'b0;
    ticks(32);
    drp_drdy = 1'b1; drp_do = 16'h5A50;
    tick();
    drp_drdy = 1'b0;
    chk("t4b_sv", 32'(sample_valid), 32'd1);
    chk("t4b_data", 32'(sample_data), 32'h5A5);
    chk("t4b_terr", 32'(timeout_err), 32'd0);
    tick();

    // 4c: timeout while clr_err is held: set wins, then clears
    clr_err = 1'b1;
    eoc_in = 1'b1; channel_in = 5'd14;
    tick();
    eoc_in = 1'b0;
    ticks(32);
    chk("t4c_terr_c33", 32'(timeout_err), 32'd0);
    tick();
    chk("t4c_set_wins", 32'(timeout_err), 32'd1);
    tick();
    chk("t4c_clr_after", 32'(timeout_err), 32'd0);
    clr_err = 1'b0;
    rd_slot = 3'd2;
    tick(); tick();
    chk("t4c_rd2", 32'(rd_data), 32'd0);

    // 5: reset mid-WAIT, drdy one cycle later
    s_sv = n_sv;
    eoc_in = 1'b1; channel_in = 5'd15;
    tick();
    eoc_in = 1'b0;
    tick();
    tick();
    reset_p = 1'b1;
    tick();
    reset_p = 1'b0;
    drp_drdy = 1'b1; drp_do = 16'h7770;
    tick();
    drp_drdy = 1'b0;
    chk("t5_den", 32'(drp_den), 32'd0);
    chk("t5_daddr", 32'(drp_daddr), 32'd0);
    chk("t5_sv", 32'(sample_valid), 32'd0);
    chk("t5_sdata", 32'(sample_data), 32'd0);
    chk("t5_terr", 32'(timeout_err), 32'd0);
    chk("t5_ovr", 32'(overrun), 32'd0);
    ticks(3);
    chk("t5_sv_cnt", 32'(n_sv - s_sv), 32'd0);
    for (int s = 0; s < 4; s++) begin
      rd_slot = 3'(s);
      tick(); tick();
      chk("t5_bank0", 32'(rd_data), 32'd0);
    end

    // 5b: eoc_in held high through reset is an event right after reset
    reset_p = 1'b1; eoc_in = 1'b1; channel_in = 5'd6;
    tick(); tick();
    reset_p = 1'b0;
    tick();
    chk("t5b_den", 32'(drp_den), 32'd1);
    chk("t5b_daddr", 32'(drp_daddr), 32'h06);
    eoc_in = 1'b0;
    tick();
    drp_drdy = 1'b1; drp_do = 16'h0010;
    tick();
    drp_drdy = 1'b0;
    chk("t5b_sv", 32'(sample_valid), 32'd1);
    chk("t5b_data", 32'(sample_data), 32'h001);
    tick();

    // 6: ramp scan over all mapped channels, two rounds
    scan_ch[0] = 5'd6;  scan_ch[1] = 5'd7;  scan_ch[2] = 5'd14; scan_ch[3] = 5'd15;
    exp_bank[0] = 12'h555; exp_bank[1] = 12'h666; exp_bank[2] = 12'h777; exp_bank[3] = 12'h888;
    for (int i = 0; i < 8; i++) begin
      xact(scan_ch[i % 4], 16'(16'h1110 * (i + 1)), 3'(i % 4));
    end
    for (int s = 0; s < 4; s++) begin
      rd_slot = 3'(s);
      tick(); tick();
      chk("t6_bank", 32'(rd_data), 32'(exp_bank[s]));
    end
    rd_slot = 3'd5;
    tick(); tick();
    chk("t6_rd5", 32'(rd_data), 32'd0);
    rd_slot = 3'd4;
    tick(); tick();
    chk("t6_rd4", 32'(rd_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
